// File: rtl/board_row_streamer.sv
// board_row_streamer: snapshots a ROWS x COLS Life board on load and streams it out row by row over valid/ready.
// Optional build define POPCOUNT_EN adds a per-frame live-cell total on pop_count.
module board_row_streamer #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 16,
  parameter int unsigned ROW_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [ROWS*COLS-1:0]   board_in,
  input  logic                   row_ready,
  output logic                   row_valid,
  output logic [COLS-1:0]        row_data,
  output logic [ROW_W-1:0]       row_idx,
  output logic                   first_row,
  output logic                   last_row,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
`ifdef POPCOUNT_EN
  ,
  output logic [$clog2(ROWS*COLS+1)-1:0] pop_count
`endif
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(ROWS - 1);

  state_t                state_q, state_d;
  logic [ROWS*COLS-1:0]  snap_q, snap_d;
  logic [ROW_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [COLS-1:0]       row_cur;
  logic                  xfer, last_xfer, accept;

  always_comb begin
    row_cur = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (idx_q == ROW_W'(r)) row_cur = snap_q[r*COLS +: COLS];
    end
  end

  // A load is only honoured when idle or on the edge that retires the final row.
  always_comb begin
    xfer      = (state_q == STREAM) && row_ready;
    last_xfer = xfer && (idx_q == LAST_IDX);
    accept    = load && ((state_q == IDLE) || last_xfer);

    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    done_d    = last_xfer;
    overrun_d = load && !accept;

    if (xfer) idx_d = last_xfer ? '0 : idx_q + ROW_W'(1);
    if (last_xfer) state_d = IDLE;
    if (accept) begin
      snap_d  = board_in;
      idx_d   = '0;
      state_d = STREAM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign row_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign row_data  = (state_q == STREAM) ? row_cur : '0;
  assign row_idx   = idx_q;
  assign first_row = (state_q == STREAM) && (idx_q == '0);
  assign last_row  = (state_q == STREAM) && (idx_q == LAST_IDX);
  assign done      = done_q;
  assign overrun   = overrun_q;

`ifdef POPCOUNT_EN
  localparam int unsigned PW = $clog2(ROWS*COLS+1);

  logic [PW-1:0] acc_q, acc_d, pop_q, pop_d, row_pop;

  // The final row is folded straight into the published total so it lands with done.
  always_comb begin
    row_pop = '0;
    for (int unsigned c = 0; c < COLS; c++) row_pop = row_pop + PW'(row_cur[c]);
    acc_d = acc_q;
    pop_d = pop_q;
    if (last_xfer) begin
      pop_d = acc_q + row_pop;
      acc_d = '0;
    end else if (xfer) begin
      acc_d = acc_q + row_pop;
    end
    if (accept) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      pop_q <= '0;
    end else begin
      acc_q <= acc_d;
      pop_q <= pop_d;
    end
  end

  assign pop_count = pop_q;
`endif

endmodule

// File: doc/board_row_streamer.md
# board_row_streamer

Reads a full 16x16 Game of Life generation (the 256-bit board produced once per generation by the next-state engine) and streams it out row by row over a valid/ready handshake, for display scan-out or host readback. Captures a snapshot on a load strobe so the engine may advance while rows are still draining. Sits between the generation engine's board output and the LED-matrix / UART row consumer.

## Interface
- ROWS, 16, number of board rows; board width is ROWS*COLS
- COLS, 16, cells per row; row_data width
- ROW_W, 4, width of row_idx; must satisfy 2**ROW_W >= ROWS
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset; the only reset
- load  input  1  request to capture board_in and start a frame
- board_in  input  ROWS*COLS  board; cell i = row*COLS+col, row r = board_in[r*COLS +: COLS]
- row_ready  input  1  consumer accepts current row
- row_valid  output  1  row_data/row_idx valid
- row_data  output  COLS  current row; row_data[c] = cell (row, c)
- row_idx  output  ROW_W  current row number, 0 first
- first_row  output  1  row_valid && row_idx==0
- last_row  output  1  row_valid && row_idx==ROWS-1
- busy  output  1  frame in progress (STREAM state)
- done  output  1  one-cycle pulse after last row accepted
- overrun  output  1  one-cycle pulse: load dropped
- pop_count  output  $clog2(ROWS*COLS+1) (9)  live cells of last frame (POPCOUNT_EN only)

## Operation
- States: IDLE, STREAM.
- Handshake: a row transfers on any rising edge with row_valid && row_ready. row_data, row_idx held stable while row_valid && !row_ready. row_valid never drops without a transfer (except reset).
- Load acceptance: load is accepted when state==IDLE, or in STREAM on the same edge the last row (ROWS-1) transfers (back-to-back). Accepted load copies board_in into the snapshot register; row counter := 0; state := STREAM.
- Load not accepted (STREAM, not final transfer): snapshot untouched, overrun pulses next cycle for one cycle; frame continues.
- STREAM: row_data = snapshot row row_idx. Transfer of row k<ROWS-1 -> row_idx k+1. Transfer of row ROWS-1 -> done pulses next cycle; state := IDLE unless back-to-back load, then STREAM with row_idx 0 of new snapshot.
- IDLE: row_valid=0, row_data=0, row_idx=0.
- Row counter wraps only via frame restart; never increments past ROWS-1.
- Reset (any time, including mid-frame): state IDLE, snapshot 0, all outputs 0 (row_valid, row_data, row_idx, first_row, last_row, busy, done, overrun, pop_count). In-flight frame abandoned, no done.

## Timing
- load accepted at edge t -> row_valid=1, row_idx=0 from cycle t+1; busy=1 from t+1.
- With row_ready held 1: one row per cycle; full frame occupies ROWS cycles; done high cycle t+ROWS+1 (the cycle after the last transfer edge).
- Back-to-back: row_valid stays 1 continuously across frames; done and row_idx=0 coincide in the same cycle.
- overrun: registered, high exactly the cycle after the dropped load edge.
- Outputs registered; no combinational path from row_ready or load to any output.

## Configuration
- POPCOUNT_EN defined: a per-row population count of each transferred row is summed into an accumulator cleared at frame start; pop_count updates to the frame total in the same cycle done pulses and holds until the next done or reset. Range 0..ROWS*COLS, no saturation needed.
- POPCOUNT_EN undefined: accumulator and pop_count port absent; all other behaviour identical.

## Test plan
- Reset then load board with only cell 0 and cell 255 set, row_ready=1 -> rows 0..15 on consecutive cycles; row 0 data 16'h0001, row 15 data 16'h8000, others 0; first_row on row 0, last_row on row 15; done one cycle after; pop_count=2.
- Backpressure: row_ready toggled 1,0,0,1,... -> row_data/row_idx stable during stalls, no row skipped or repeated, 16 transfers total.
- Load while busy at row_idx=5 -> overrun pulses one cycle, remaining rows come from original snapshot, done as normal.
- Back-to-back: load asserted on edge of row 15 transfer with all-ones board -> no row_valid gap, next row 0 = 16'hFFFF, done and row_idx=0 same cycle, final pop_count=256.
- Reset asserted at row_idx=7 -> next cycle all outputs 0, no done; fresh load restarts at row 0.
- Build without POPCOUNT_EN -> first two scenarios produce identical row streams and done timing.
